// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide unit: operand width, md_op codes, FSM state codes.
package md_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OpW  = 3;

  localparam logic [OpW-1:0] MD_MULT  = 3'd0;
  localparam logic [OpW-1:0] MD_MULTU = 3'd1;
  localparam logic [OpW-1:0] MD_DIV   = 3'd2;
  localparam logic [OpW-1:0] MD_DIVU  = 3'd3;
  localparam logic [OpW-1:0] MD_MTHI  = 3'd4;
  localparam logic [OpW-1:0] MD_MTLO  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface md_if;
  import md_pkg::*;

  logic            start;
  logic [OpW-1:0]  md_op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            cancel;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, md_op, a, b, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, cancel,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_div_core.sv
// Combinational signed/unsigned divider with MIPS-style divide-by-zero result (hi=a, lo=all ones).
module md_div_core
  import md_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] uq;
  logic [XLEN-1:0] ur;

  // Sign-magnitude divide. 0x8000_0000 / -1 falls out as quotient 0x8000_0000, remainder 0.
  always_comb begin
    neg_a = signed_i & a_i[XLEN-1];
    neg_b = signed_i & b_i[XLEN-1];
    abs_a = neg_a ? (~a_i + 1'b1) : a_i;
    abs_b = neg_b ? (~b_i + 1'b1) : b_i;
    uq    = '0;
    ur    = '0;
    quo_o = '1;
    rem_o = a_i;
    if (b_i != '0) begin
      uq    = abs_a / abs_b;
      ur    = abs_a % abs_b;
      quo_o = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
      rem_o = neg_a ? (~ur + 1'b1) : ur;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Optional macro MD_CANCEL_EN enables
// flushing an in-flight op (and suppressing a same-cycle start) via bus.cancel.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset_n,
  md_if.slave bus
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] phi_q, phi_d;
  logic [XLEN-1:0] plo_q, plo_d;

  logic            start_ok;
  logic [63:0]     a_ext;
  logic [63:0]     b_ext;
  logic [63:0]     prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  // Sign/zero extension to 64 bits lets one multiplier serve both MULT and MULTU.
  always_comb begin
    a_ext = (bus.md_op == MD_MULT) ? {{XLEN{bus.a[XLEN-1]}}, bus.a} : {{XLEN{1'b0}}, bus.a};
    b_ext = (bus.md_op == MD_MULT) ? {{XLEN{bus.b[XLEN-1]}}, bus.b} : {{XLEN{1'b0}}, bus.b};
    prod  = a_ext * b_ext;
  end

  md_div_core u_div_core (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .signed_i (bus.md_op == MD_DIV),
    .quo_o    (quo),
    .rem_o    (rem)
  );

`ifdef MD_CANCEL_EN
  assign start_ok = bus.start & ~bus.cancel;
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign start_ok      = bus.start;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          case (bus.md_op)
            MD_MULT, MD_MULTU: begin
              state_d = S_MUL;
              cnt_d   = CntW'(MUL_CYCLES);
              phi_d   = prod[63:32];
              plo_d   = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
              state_d = S_DIV;
              cnt_d   = CntW'(DIV_CYCLES);
              phi_d   = rem;
              plo_d   = quo;
            end
            MD_MTHI: hi_d = bus.a;
            MD_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
`ifdef MD_CANCEL_EN
        if (bus.cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else
`endif
        if (cnt_q == CntW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hi_d    = phi_q;
          lo_d    = plo_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {hi,lo} queued at launch, popped when busy falls.
module tb_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  md_if bus ();

  md_unit #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sp;
    int sa, sbv, q, r;
    case (op)
      MD_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      MD_MULTU: return {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a; sbv = b; q = sa / sbv; r = sa % sbv;
        return {r, q};
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Called at a negedge; start is high across the next posedge. Returns at the following negedge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.md_op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    logic [63:0] e;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    launch(MD_MTHI, 32'h1111_1111, 32'h0);
    launch(MD_MTLO, 32'h2222_2222, 32'h0);
    launch(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.hi, bus.lo} !== 64'h0) begin
      failures++; $display("FAIL midreset_hilo got=%h exp=0", {bus.hi, bus.lo});
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    sb_q.push_back(model(MD_MULTU, 32'd6, 32'd7));
    launch(MD_MULTU, 32'd6, 32'd7);
    wait_idle(n);
    e = sb_q.pop_front();
    checks++; if (n != 5) begin failures++; $display("FAIL post_reset_cycles got=%0d exp=5", n); end
    checks++; if ({bus.hi, bus.lo} !== e) begin
      failures++; $display("FAIL post_reset_result got=%h exp=%h", {bus.hi, bus.lo}, e);
    end
  endtask

  task automatic test_mul_div();
    int n;
    logic [63:0] e;
    logic [2:0]  ops [6] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_DIVU, MD_DIV};
    logic [31:0] as [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7, 32'h1234,
                            32'h8000_0000};
    logic [31:0] bs [6] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [63:0] ex [6] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFA}, {32'h2, 32'hFFFF_FFFA},
                            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'h3},
                            {32'h1234, 32'hFFFF_FFFF}, {32'h0, 32'h8000_0000}};
    int cyc [6] = '{5, 5, 10, 10, 10, 10};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(ex[i]);
      launch(ops[i], as[i], bs[i]);
      wait_idle(n);
      e = sb_q.pop_front();
      checks++; if (n != cyc[i]) begin
        failures++; $display("FAIL muldiv%0d_cycles got=%0d exp=%0d", i, n, cyc[i]);
      end
      checks++; if ({bus.hi, bus.lo} !== e) begin
        failures++; $display("FAIL muldiv%0d_result got=%h exp=%h", i, {bus.hi, bus.lo}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mt();
    int n;
    logic [63:0] e;
    @(negedge clk);
    launch(MD_MTHI, 32'hDEAD_BEEF, 32'h0);
    checks++; if (bus.hi !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL mthi_hi got=%h exp=deadbeef", bus.hi);
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", bus.busy); end
    launch(MD_MTLO, 32'hCAFE_0001, 32'h0);
    checks++; if (bus.lo !== 32'hCAFE_0001) begin
      failures++; $display("FAIL mtlo_lo got=%h exp=cafe0001", bus.lo);
    end
    // Undefined op codes must be ignored.
    launch(3'd6, 32'h5555_5555, 32'h0);
    launch(3'd7, 32'h6666_6666, 32'h0);
    checks++; if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'hDEAD_BEEF, 32'hCAFE_0001}) begin
      failures++; $display("FAIL undef_op got=%b/%h/%h exp=0/deadbeef/cafe0001",
                           bus.busy, bus.hi, bus.lo);
    end
    sb_q.push_back(model(MD_MULT, 32'd3, 32'd4));
    launch(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    launch(MD_MTLO, 32'h0000_0055, 32'h0);
    wait_idle(n);
    e = sb_q.pop_front();
    checks++; if (n != 3) begin failures++; $display("FAIL mt_during_busy_cycles got=%0d exp=3", n); end
    checks++; if ({bus.hi, bus.lo} !== e) begin
      failures++; $display("FAIL mt_during_busy_result got=%h exp=%h", {bus.hi, bus.lo}, e);
    end
  endtask

  task automatic test_cancel();
    int n;
    logic [63:0] e;
    @(negedge clk);
    launch(MD_MTHI, 32'hAAAA_0000, 32'h0);
    launch(MD_MTLO, 32'h0000_BBBB, 32'h0);
    launch(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
`ifdef MD_CANCEL_EN
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.hi, bus.lo} !== {32'hAAAA_0000, 32'h0000_BBBB}) begin
      failures++; $display("FAIL cancel_hilo got=%h exp=aaaa00000000bbbb", {bus.hi, bus.lo});
    end
    bus.cancel = 1'b1;
    launch(MD_MTHI, 32'h1234_5678, 32'h0);
    bus.cancel = 1'b0;
    checks++; if (bus.hi !== 32'hAAAA_0000) begin
      failures++; $display("FAIL cancel_start_hi got=%h exp=aaaa0000", bus.hi);
    end
`else
    sb_q.push_back({32'd2, 32'd14});
    wait_idle(n);
    n = n + 3;
    e = sb_q.pop_front();
    checks++; if (n != 10) begin failures++; $display("FAIL nocancel_cycles got=%0d exp=10", n); end
    checks++; if ({bus.hi, bus.lo} !== e) begin
      failures++; $display("FAIL nocancel_result got=%h exp=%h", {bus.hi, bus.lo}, e);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] e;
    logic [2:0]  op;
    logic [31:0] a, b;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      op = 3'(i % 4);
      a  = $urandom;
      b  = (i == 3) ? 32'h0 : $urandom_range(1, 32'h7FFF);
      if (i % 2 == 0) b = -b;
      sb_q.push_back(model(op, a, b));
      launch(op, a, b);
      wait_idle(n);
      e = sb_q.pop_front();
      checks++; if ({bus.hi, bus.lo} !== e || n != ((op < 2) ? 5 : 10)) begin
        failures++; $display("FAIL b2b%0d op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d", i, op, a, b,
                             {bus.hi, bus.lo}, n, e, (op < 2) ? 5 : 10);
      end
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
    bus.a      = 32'h0;
    bus.b      = 32'h0;
    bus.cancel = 1'b0;
    test_reset();
    test_mul_div();
    test_mt();
    test_cancel();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
